// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, dispatcher state encoding, command layout and small helpers
// shared by the ALU command dispatcher and its FIFO.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_INV = 2'd3;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } disp_state_e;

    // Command layout at the default ALU width; the dispatcher mirrors it at its own WIDTH.
    typedef struct packed {
        logic [1:0]           op;
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
    } alu_cmd_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return 16'hFFFF;
        end else begin
            return val + 16'd1;
        end
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous show-ahead FIFO; the head entry is readable whenever not empty.
// Pointers wrap naturally, so DEPTH must be a power of two.
module alu_cmd_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_dispatcher.sv
// alu_cmd_dispatcher: buffers {op,a,b} commands, issues them one at a time to a fixed-latency
// ALU and returns results in order. Define ALU_DISPATCH_STATS_EN for stat_done/stat_err counters.
module alu_cmd_dispatcher
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [1:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic [1:0]       rsp_op,
    output logic             rsp_err
`ifdef ALU_DISPATCH_STATS_EN
    ,
    output logic [15:0]      stat_done,
    output logic [15:0]      stat_err
`endif
);

    localparam int CMD_W   = 2 + 2 * WIDTH;
    localparam int LAT_MAX = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    disp_state_e      r_state;
    disp_state_e      w_next_state;
    logic [CNT_W-1:0] r_lat_cnt;
    logic [1:0]       r_alu_ctrl;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_y;
    logic [1:0]       r_rsp_op;
    logic             r_rsp_err;

    cmd_t             w_push_cmd;
    cmd_t             w_head;
    logic [CMD_W-1:0] w_head_data;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;
    logic             w_issue;
    logic             w_reject;
    logic             w_capture;
    logic             w_rsp_done;
    logic             w_lat_last;

    assign w_push_cmd = '{op: cmd_op, a: cmd_a, b: cmd_b};
    assign w_head     = cmd_t'(w_head_data);
    assign cmd_ready  = ~w_fifo_full;
    assign w_lat_last = (r_lat_cnt == CNT_W'(1));

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (cmd_valid),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_next_state = (w_head.op == OP_INV) ? ST_RESP : ST_EXEC;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (w_lat_last) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM strobes: pop/issue in IDLE, capture at end of EXEC, release on handshake.
    always_comb begin
        w_pop      = 1'b0;
        w_issue    = 1'b0;
        w_reject   = 1'b0;
        w_capture  = 1'b0;
        w_rsp_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop    = 1'b1;
                    w_issue  = (w_head.op != OP_INV);
                    w_reject = (w_head.op == OP_INV);
                end else begin
                    w_pop = 1'b0;
                end
            end
            ST_EXEC: w_capture  = w_lat_last;
            ST_RESP: w_rsp_done = rsp_ready;
            default: w_pop      = 1'b0;
        endcase
    end

    // Latency counter: loaded on issue, counts down through EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_cnt <= '0;
        end else if (w_issue) begin
            r_lat_cnt <= (w_head.op == OP_MUL) ? CNT_W'(MUL_LAT) : CNT_W'(ADD_LAT);
        end else if (r_state == ST_EXEC) begin
            r_lat_cnt <= r_lat_cnt - CNT_W'(1);
        end else begin
            r_lat_cnt <= r_lat_cnt;
        end
    end

    // ALU drive registers; invalid ops leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_ctrl <= OP_ADD;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
        end else if (w_issue) begin
            r_alu_ctrl <= w_head.op;
            r_alu_a    <= w_head.a;
            r_alu_b    <= w_head.b;
        end else begin
            r_alu_ctrl <= r_alu_ctrl;
            r_alu_a    <= r_alu_a;
            r_alu_b    <= r_alu_b;
        end
    end

    // Response registers; alu_ctrl still holds the opcode at capture time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_op    <= OP_ADD;
            r_rsp_err   <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_y     <= alu_y;
            r_rsp_op    <= r_alu_ctrl;
            r_rsp_err   <= 1'b0;
        end else if (w_reject) begin
            r_rsp_valid <= 1'b1;
            r_rsp_y     <= '0;
            r_rsp_op    <= OP_INV;
            r_rsp_err   <= 1'b1;
        end else if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= r_rsp_valid;
        end
    end

    assign alu_ctrl  = r_alu_ctrl;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign rsp_op    = r_rsp_op;
    assign rsp_err   = r_rsp_err;

`ifdef ALU_DISPATCH_STATS_EN
    logic [15:0] r_stat_done;
    logic [15:0] r_stat_err;

    // Saturating counts of handshaken responses, split by error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_done <= 16'd0;
            r_stat_err  <= 16'd0;
        end else if (w_rsp_done) begin
            if (r_rsp_err) begin
                r_stat_err <= sat_inc16(r_stat_err);
            end else begin
                r_stat_done <= sat_inc16(r_stat_done);
            end
        end else begin
            r_stat_done <= r_stat_done;
            r_stat_err  <= r_stat_err;
        end
    end

    assign stat_done = r_stat_done;
    assign stat_err  = r_stat_err;
`endif

endmodule

// File: tb/tb_alu_cmd_dispatcher.sv
// tb_alu_cmd_dispatcher: table-driven directed bench for alu_cmd_dispatcher with a simple ALU model.
// Covers ALU_DISPATCH_STATS_EN counters when that macro is defined.
module tb_alu_cmd_dispatcher;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [1:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_y;
    logic [1:0]  rsp_op;
    logic        rsp_err;
`ifdef ALU_DISPATCH_STATS_EN
    logic [15:0] stat_done;
    logic [15:0] stat_err;
`endif

    int tests;
    int fails;

    typedef struct {
        alu_cmd_t    cmd;
        logic [31:0] exp_y;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];

    alu_cmd_dispatcher #(
        .WIDTH   (32),
        .DEPTH   (4),
        .ADD_LAT (1),
        .MUL_LAT (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_ctrl  (alu_ctrl),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_op    (rsp_op),
        .rsp_err   (rsp_err)
`ifdef ALU_DISPATCH_STATS_EN
        ,
        .stat_done (stat_done),
        .stat_err  (stat_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 2-bit control, result truncated to 32 bits.
    always_comb begin
        case (alu_ctrl)
            OP_ADD:  alu_y = alu_a + alu_b;
            OP_SUB:  alu_y = alu_a - alu_b;
            OP_MUL:  alu_y = alu_a * alu_b;
            default: alu_y = 32'd0;
        endcase
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] y, input logic err, input int lat);
        vec_t v;
        v.cmd.op  = op;
        v.cmd.a   = a;
        v.cmd.b   = b;
        v.exp_y   = y;
        v.exp_err = err;
        v.exp_lat = lat;
        return v;
    endfunction

    // Present one command and return #1 after the edge that accepted it.
    task automatic push_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("push_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Single command on an idle dispatcher with rsp_ready=1; checks latency, stability, response.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        lat = 0;
        push_cmd(v.cmd.op, v.cmd.a, v.cmd.b);
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid) break;
            check($sformatf("v%0d_alu_ctrl", idx), {30'd0, alu_ctrl}, {30'd0, v.cmd.op});
            check($sformatf("v%0d_alu_a", idx), alu_a, v.cmd.a);
            check($sformatf("v%0d_alu_b", idx), alu_b, v.cmd.b);
        end
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d_rsp_y", idx), rsp_y, v.exp_y);
        check($sformatf("v%0d_rsp_op", idx), {30'd0, rsp_op}, {30'd0, v.cmd.op});
        check($sformatf("v%0d_rsp_err", idx), {31'd0, rsp_err}, {31'd0, v.exp_err});
        @(posedge clk);
        #1;
        check($sformatf("v%0d_rsp_drop", idx), {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  bp_op [5];
        logic [31:0] bp_a  [5];
        logic [31:0] bp_b  [5];
        logic [31:0] bp_y  [5];
        int          n;
        logic        saw_rsp;

        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_a     = 32'd0;
        cmd_b     = 32'd0;
        rsp_ready = 1'b1;

        vecs[0] = mk(OP_ADD, 32'd50,         32'd60,         32'd110,        1'b0, 2);
        vecs[1] = mk(OP_SUB, 32'd100,        32'd61,         32'd39,         1'b0, 2);
        vecs[2] = mk(OP_MUL, 32'd5,          32'd56,         32'd280,        1'b0, 4);
        vecs[3] = mk(OP_INV, 32'd52,         32'd54,         32'd0,          1'b1, 1);
        vecs[4] = mk(OP_SUB, 32'd0,          32'd10,         32'hFFFF_FFF6,  1'b0, 2);
        vecs[5] = mk(OP_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 2);
        vecs[6] = mk(OP_MUL, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b0, 4);
        vecs[7] = mk(OP_ADD, 32'd100,        32'd51,         32'd151,        1'b0, 2);

        // Reset state
        #3;
        check("rst_alu_ctrl", {30'd0, alu_ctrl}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_y", rsp_y, 32'd0);
        check("rst_rsp_op", {30'd0, rsp_op}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Invalid op must not disturb the ALU drive registers
        run_vec(mk(OP_MUL, 32'd7, 32'd3, 32'd21, 1'b0, 4), 8);
        run_vec(mk(OP_INV, 32'd52, 32'd54, 32'd0, 1'b1, 1), 9);
        check("inv_keep_ctrl", {30'd0, alu_ctrl}, {30'd0, OP_MUL});
        check("inv_keep_a", alu_a, 32'd7);
        check("inv_keep_b", alu_b, 32'd3);

        // Back-pressure: one in flight plus four queued fills the FIFO
        bp_op[0] = OP_ADD; bp_a[0] = 32'd100; bp_b[0] = 32'd51; bp_y[0] = 32'd151;
        bp_op[1] = OP_SUB; bp_a[1] = 32'd50;  bp_b[1] = 32'd11; bp_y[1] = 32'd39;
        bp_op[2] = OP_MUL; bp_a[2] = 32'd5;   bp_b[2] = 32'd56; bp_y[2] = 32'd280;
        bp_op[3] = OP_ADD; bp_a[3] = 32'd50;  bp_b[3] = 32'd60; bp_y[3] = 32'd110;
        bp_op[4] = OP_SUB; bp_a[4] = 32'd0;   bp_b[4] = 32'd10; bp_y[4] = 32'hFFFF_FFF6;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                check("bp_ready_before_5th", {31'd0, cmd_ready}, 32'd1);
            end
            push_cmd(bp_op[i], bp_a[i], bp_b[i]);
        end
        check("bp_full_ready", {31'd0, cmd_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_still_full", {31'd0, cmd_ready}, 32'd0);
        check("bp_held_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_held_y", rsp_y, 32'd151);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("bp%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("bp%0d_y", i), rsp_y, bp_y[i]);
            check($sformatf("bp%0d_op", i), {30'd0, rsp_op}, {30'd0, bp_op[i]});
            check($sformatf("bp%0d_err", i), {31'd0, rsp_err}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("bp_ready_after", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Reset during a mul with two commands queued
        push_cmd(OP_MUL, 32'd5, 32'd56);
        push_cmd(OP_ADD, 32'd1, 32'd1);
        push_cmd(OP_ADD, 32'd2, 32'd2);
        check("mid_exec_ctrl", {30'd0, alu_ctrl}, {30'd0, OP_MUL});
        rst_n = 1'b0;
        #1;
        check("mrst_alu_ctrl", {30'd0, alu_ctrl}, 32'd0);
        check("mrst_alu_a", alu_a, 32'd0);
        check("mrst_alu_b", alu_b, 32'd0);
        check("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mrst_rsp_y", rsp_y, 32'd0);
        check("mrst_rsp_op", {30'd0, rsp_op}, 32'd0);
        check("mrst_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        saw_rsp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        check("mrst_no_rsp", {31'd0, saw_rsp}, 32'd0);
        check("mrst_no_issue", alu_a, 32'd0);
        @(posedge clk);
        #1;

`ifdef ALU_DISPATCH_STATS_EN
        check("stat_done_rst", {16'd0, stat_done}, 32'd0);
        check("stat_err_rst", {16'd0, stat_err}, 32'd0);
        run_vec(vecs[0], 10);
        run_vec(vecs[3], 11);
        run_vec(vecs[1], 12);
        run_vec(vecs[3], 13);
        run_vec(vecs[2], 14);
        check("stat_done", {16'd0, stat_done}, 32'd3);
        check("stat_err", {16'd0, stat_err}, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
